// File: rtl/ps2_ascii_decoder_if.sv
// Key-event input and buffered ASCII output bundle for ps2_ascii_decoder.
// master = decoder side, slave = key source / byte consumer side.
interface ps2_ascii_decoder_if #(
    parameter int unsigned FIFO_AW = 3
);
    logic [10:0]      ps2_key;
    logic [7:0]       ascii_byte;
    logic             ascii_valid;
    logic             ascii_ready;
    logic             overflow;
    logic [FIFO_AW:0] fifo_count;

    modport master (
        input  ps2_key,
        input  ascii_ready,
        output ascii_byte,
        output ascii_valid,
        output overflow,
        output fifo_count
    );

    modport slave (
        output ps2_key,
        output ascii_ready,
        input  ascii_byte,
        input  ascii_valid,
        input  overflow,
        input  fifo_count
    );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// Set-2 ps2_key event stream to ASCII bytes, buffered in a FWFT FIFO.
// Define PS2_ASCII_KEYPAD_EN to also translate numeric keypad keys.
module ps2_ascii_decoder #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    ps2_ascii_decoder_if.master bus
);
    localparam int unsigned          DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]     CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]     CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]   PTR_ONE  = FIFO_AW'(1);

    logic       key_tog;
    logic       key_make;
    logic       key_ext;
    logic [7:0] key_code;

    logic tog_q, primed_q;
    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;
    logic caps_q, caps_d;
    logic [7:0] code_q;
    logic       code_v_q, code_v_d;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic       evt;
    logic       shift;
    logic       letter_v;
    logic [7:0] letter_lc;
    logic       lut_v;
    logic [7:0] lut_char;
    logic       empty, full, pop, push_ok, drop;

    assign key_tog  = bus.ps2_key[10];
    assign key_make = bus.ps2_key[9];
    assign key_ext  = bus.ps2_key[8];
    assign key_code = bus.ps2_key[7:0];

    // The first edge after reset only captures the toggle bit.
    assign evt   = primed_q & (key_tog ^ tog_q);
    assign shift = lshift_q | rshift_q;

    always_comb begin
        letter_v  = 1'b1;
        letter_lc = 8'h00;
        case (key_code)
            8'h1C: letter_lc = "a";
            8'h32: letter_lc = "b";
            8'h21: letter_lc = "c";
            8'h23: letter_lc = "d";
            8'h24: letter_lc = "e";
            8'h2B: letter_lc = "f";
            8'h34: letter_lc = "g";
            8'h33: letter_lc = "h";
            8'h43: letter_lc = "i";
            8'h3B: letter_lc = "j";
            8'h42: letter_lc = "k";
            8'h4B: letter_lc = "l";
            8'h3A: letter_lc = "m";
            8'h31: letter_lc = "n";
            8'h44: letter_lc = "o";
            8'h4D: letter_lc = "p";
            8'h15: letter_lc = "q";
            8'h2D: letter_lc = "r";
            8'h1B: letter_lc = "s";
            8'h2C: letter_lc = "t";
            8'h3C: letter_lc = "u";
            8'h2A: letter_lc = "v";
            8'h1D: letter_lc = "w";
            8'h22: letter_lc = "x";
            8'h35: letter_lc = "y";
            8'h1A: letter_lc = "z";
            default: letter_v = 1'b0;
        endcase
    end

    always_comb begin
        lut_v    = 1'b0;
        lut_char = 8'h00;
        if (!key_ext) begin
            if (letter_v) begin
                lut_v    = 1'b1;
                lut_char = (shift ^ caps_q) ? (letter_lc - 8'h20) : letter_lc;
            end else begin
                lut_v = 1'b1;
                case (key_code)
                    8'h16: lut_char = shift ? "!" : "1";
                    8'h1E: lut_char = shift ? "@" : "2";
                    8'h26: lut_char = shift ? "#" : "3";
                    8'h25: lut_char = shift ? "$" : "4";
                    8'h2E: lut_char = shift ? 8'h25 : "5";
                    8'h36: lut_char = shift ? "^" : "6";
                    8'h3D: lut_char = shift ? "&" : "7";
                    8'h3E: lut_char = shift ? "*" : "8";
                    8'h46: lut_char = shift ? "(" : "9";
                    8'h45: lut_char = shift ? ")" : "0";
                    8'h41: lut_char = shift ? "<" : ",";
                    8'h49: lut_char = shift ? ">" : ".";
                    8'h4A: lut_char = shift ? "?" : "/";
                    8'h4C: lut_char = shift ? ":" : ";";
                    8'h52: lut_char = shift ? 8'h22 : 8'h27;
                    8'h4E: lut_char = shift ? "_" : "-";
                    8'h55: lut_char = shift ? "+" : "=";
                    8'h29: lut_char = 8'h20;
                    8'h5A: lut_char = 8'h0D;
                    8'h66: lut_char = 8'h08;
`ifdef PS2_ASCII_KEYPAD_EN
                    8'h70: lut_char = "0";
                    8'h69: lut_char = "1";
                    8'h72: lut_char = "2";
                    8'h7A: lut_char = "3";
                    8'h6B: lut_char = "4";
                    8'h73: lut_char = "5";
                    8'h74: lut_char = "6";
                    8'h6C: lut_char = "7";
                    8'h75: lut_char = "8";
                    8'h7D: lut_char = "9";
                    8'h71: lut_char = ".";
                    8'h79: lut_char = "+";
                    8'h7B: lut_char = "-";
                    8'h7C: lut_char = "*";
`endif
                    default: lut_v = 1'b0;
                endcase
            end
        end
`ifdef PS2_ASCII_KEYPAD_EN
        else begin
            lut_v = 1'b1;
            case (key_code)
                8'h4A:   lut_char = "/";
                8'h5A:   lut_char = 8'h0D;
                default: lut_v = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        if (evt && !key_ext) begin
            if (key_code == 8'h12) lshift_d = key_make;
            if (key_code == 8'h59) rshift_d = key_make;
            if (key_code == 8'h58 && key_make) caps_d = ~caps_q;
        end
        code_v_d = evt & key_make & lut_v;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = ~empty & bus.ascii_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push_ok = code_v_q & (~full | pop);
    assign drop    = code_v_q & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_q      <= 1'b0;
            primed_q   <= 1'b0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            caps_q     <= 1'b0;
            code_q     <= '0;
            code_v_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tog_q      <= key_tog;
            primed_q   <= 1'b1;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            caps_q     <= caps_d;
            code_q     <= lut_char;
            code_v_q   <= code_v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= code_q;
    end

    assign bus.ascii_valid = ~empty;
    assign bus.ascii_byte  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.overflow    = overflow_q;
    assign bus.fifo_count  = count_q;
endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Converts the 11-bit `ps2_key` event stream into buffered ASCII bytes. It is the inverse of `text_writer`, which turns ASCII into `ps2_key` events. It sits beside `cv_keyboard` on `clk_sys` and feeds keyboard-originated text to consumers such as a BASIC listing capture or a debug console. Output goes through a small first-word-fall-through FIFO with a valid/ready handshake.

## Interface
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW entries.
- `clk` in 1: system clock (`clk_sys`).
- `reset` in 1: asynchronous, active-high.
- `ps2_key` in 11:
  - [10] toggles once per key event.
  - [9] 1 = make, 0 = break.
  - [8] E0-extended.
  - [7:0] set-2 scancode.
- `ascii_byte` out 8: FIFO head byte. Meaningful only while `ascii_valid` = 1.
- `ascii_valid` out 1: FIFO is non-empty.
- `ascii_ready` in 1: consumer accepts the head byte. A byte is popped on any edge where `ascii_valid` & `ascii_ready`.
- `overflow` out 1: sticky. Set when a translated byte is dropped because the FIFO is full. Cleared only by `reset`.
- `fifo_count` out FIFO_AW+1: current occupancy, 0..2^FIFO_AW.

## Operation
- **Reset state:**
  - All outputs 0; `ascii_byte` = 8'h00.
  - FIFO empty; shift, caps and primed flags cleared.
- **Event detect:**
  - `tog_q` registers `ps2_key[10]` every cycle.
  - An event is `ps2_key[10] != tog_q` while `primed` = 1.
  - `primed` sets on the first edge after reset deasserts. No event is decoded on that edge, so a high toggle bit at reset release is not a keypress.
- **Modifier tracking** (applies to make and break):
  - 0x12 and 0x59, non-extended: make sets, break clears `lshift`/`rshift`.
  - 0x58 make: toggles `caps`. 0x58 break: ignored.
  - Modifier events never emit a byte.
- **Translation:** make events only; break events never emit.
  - `shift` = lshift | rshift.
  - Letters 0x1C a, 0x32 b, 0x21 c, 0x23 d, 0x24 e, 0x2B f, 0x34 g, 0x33 h, 0x43 i, 0x3B j, 0x42 k, 0x4B l, 0x3A m, 0x31 n, 0x44 o, 0x4D p, 0x15 q, 0x2D r, 0x1B s, 0x2C t, 0x3C u, 0x2A v, 0x1D w, 0x22 x, 0x35 y, 0x1A z.
  - Letters are uppercase when shift ^ caps.
  - Digit row 0x16,1E,26,25,2E,36,3D,3E,46,45 → '1'..'9','0'. Shifted: `!@#$%^&*()`.
  - Punctuation, unshifted/shifted: 0x41 `,<`, 0x49 `.>`, 0x4A `/?`, 0x4C `;:`, 0x52 `'"`, 0x4E `-_`, 0x55 `=+`. Caps has no effect on these.
  - 0x29 → 0x20, 0x5A → 0x0D, 0x66 → 0x08, independent of shift.
  - Extended events are discarded except under the configuration macro below.
  - Unmapped codes are discarded.
- **FIFO push/pop:**
  - Full, no pop: the push is dropped and `overflow` sets.
  - Full with simultaneous pop: the push is accepted and `fifo_count` is unchanged.
  - Empty: no bypass. A byte is visible only after it is written.
  - Pointers wrap modulo 2^FIFO_AW.
- **Reset mid-stream:** FIFO contents are lost, modifiers are cleared, and `primed` is re-armed.

## Timing
- Edge N: event sampled (toggle compare, modifier update, lookup into `code_q`/`code_v`).
- Edge N+1: FIFO write.
- After N+1, with an empty FIFO: `ascii_valid` = 1 and `ascii_byte` = char. Latency is 2 edges from the toggle change.
- Throughput: one event per cycle. Back-to-back toggles on consecutive edges each decode.
- Modifier updates are applied at edge N and affect an event sampled at N+1.
- Pop at edge M: the next head appears after M. `ascii_valid` drops after M if the FIFO becomes empty.
- `ascii_byte` holds stable while `ascii_valid` & !`ascii_ready`.

## Configuration
- `PS2_ASCII_KEYPAD_EN` defined:
  - Keypad digits 0x70 '0', 0x69 '1', 0x72 '2', 0x7A '3', 0x6B '4', 0x73 '5', 0x74 '6', 0x6C '7', 0x75 '8', 0x7D '9'.
  - Keypad symbols 0x71 '.', 0x79 '+', 0x7B '-', 0x7C '*'.
  - Extended E0 4A → '/', E0 5A → 0x0D.
  - Keypad keys ignore shift and caps.
- Not defined: all of the above codes are discarded. No keypad logic is synthesized.

## Test plan
- Reset with `ps2_key` = 11'h400 held, release, hold 10 cycles → `ascii_valid` stays 0 and `fifo_count` = 0.
- Make 0x1C (toggle change at edge N), `ascii_ready` = 1 → `ascii_valid` = 1, `ascii_byte` = 0x61 after N+1, popped next edge. Break 0x1C → no output.
- Shift make 0x12, make 0x16, shift break, caps make 0x58, make 0x1C → bytes 0x21 then 0x41. Repeat after a second caps make → 0x61.
- `ascii_ready` = 0 with FIFO_AW = 3: push 9 make 0x29 events → `fifo_count` = 8, `overflow` = 1. Drain → eight 0x20 bytes. `overflow` stays 1 until reset.
- Full FIFO: push and pop on the same edge → `fifo_count` stays 8, new byte lands at tail, `overflow` unchanged.
- With `PS2_ASCII_KEYPAD_EN`: make 0x70 → 0x30, E0 5A → 0x0D. Without it: both produce no output.
